// File: rtl/uart_tx_fifo_pkg.sv
// Shared constants and helpers for the UART transmit buffer and the
// matching receive-side FIFO.
package uart_tx_fifo_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_FRAME_CYCLES = 10;
  localparam int FIFO_DEPTH        = 8;
  localparam int FIFO_ADDR_W       = 3;

  typedef enum logic [1:0] {
    FIFO_HOLD = 2'b00,
    FIFO_PUSH = 2'b01,
    FIFO_POP  = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e fifo_op(input logic push, input logic pop);
    return fifo_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// CPU-side write port and transmitter-side load port of the UART transmit buffer.
interface uart_tx_fifo_if
  import uart_tx_fifo_pkg::*;
#(
  parameter int ADDR_W = FIFO_ADDR_W
) ();

  // Handshake: a byte moves into the FIFO on every edge where wr_i=1 and
  // (~full_o | uart_wr_o); it moves out on every edge where uart_wr_o=1,
  // which the buffer only raises while uart_busy_i=0 and it is not empty.
  logic                   wr_i;
  logic [UART_DATA_W-1:0] dat_i;
  logic                   full_o;
  logic                   empty_o;
  logic [ADDR_W:0]        count_o;
  logic                   overflow_o;
  logic                   clr_ovf_i;
  logic                   idle_o;
  logic                   uart_wr_o;
  logic [UART_DATA_W-1:0] uart_dat_o;
  logic                   uart_busy_i;

  modport slave (
    input  wr_i, dat_i, clr_ovf_i, uart_busy_i,
    output full_o, empty_o, count_o, overflow_o, idle_o, uart_wr_o, uart_dat_o
  );

  modport master (
    output wr_i, dat_i, clr_ovf_i, uart_busy_i,
    input  full_o, empty_o, count_o, overflow_o, idle_o, uart_wr_o, uart_dat_o
  );

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Generic single-clock FIFO: register array, wrapping pointers and an
// occupancy counter. A write at full is accepted when a pop frees the slot.
module sync_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = FIFO_ADDR_W,
  parameter int W      = UART_DATA_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_req,
  input  logic            pop,
  input  logic [W-1:0]    din,
  output logic [W-1:0]    dout,
  output logic [ADDR_W:0] count,
  output logic            full,
  output logic            empty,
  output logic            drop
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);

  logic [W-1:0]      mem [DEPTH];
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] wr_ptr;
  logic              pop_ok;
  logic              push;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign pop_ok = pop & ~empty;
  assign push   = wr_req & (~full | pop_ok);
  assign drop   = wr_req & full & ~pop_ok;
  assign dout   = mem[rd_ptr];

  // Storage is deliberately left out of reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case (fifo_op(push, pop_ok))
        FIFO_PUSH: count <= count + 1'b1;
        FIFO_POP:  count <= count - 1'b1;
        default:   count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit buffer: queues CPU bytes and loads them into the transmitter
// whenever it reports not-busy, with a sticky overflow flag and idle status.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic           ser_clk,
  input  logic           sys_rst_i,
  uart_tx_fifo_if.slave  bus
);

  logic pop;
  logic drop;
  logic empty;
  logic overflow_q;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .W      (UART_DATA_W)
  ) u_fifo (
    .clk    (ser_clk),
    .rst_n  (sys_rst_i),
    .wr_req (bus.wr_i),
    .pop    (pop),
    .din    (bus.dat_i),
    .dout   (bus.uart_dat_o),
    .count  (bus.count_o),
    .full   (bus.full_o),
    .empty  (empty),
    .drop   (drop)
  );

  // The transmitter raises busy right after a load, so one strobe per byte.
  assign pop            = ~empty & ~bus.uart_busy_i;
  assign bus.uart_wr_o  = pop;
  assign bus.empty_o    = empty;
  assign bus.idle_o     = empty & ~bus.uart_busy_i;
  assign bus.overflow_o = overflow_q;

  always_ff @(posedge ser_clk or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (bus.clr_ovf_i) begin
      overflow_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a transmitter busy model and a
// scoreboard that checks every load strobe against the expected byte queue.
module tb_uart_tx_fifo;
  import uart_tx_fifo_pkg::*;

  logic ser_clk;
  logic sys_rst_i;
  logic hold_busy;
  int   busy_cnt = 0;
  int   cyc = 0;

  logic [UART_DATA_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_strobes = 0;
  bit check_spacing = 0;
  bit have_last = 0;
  int last_cyc = 0;

  uart_tx_fifo_if #(.ADDR_W(FIFO_ADDR_W)) bus ();

  uart_tx_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (FIFO_ADDR_W)
  ) dut (
    .ser_clk   (ser_clk),
    .sys_rst_i (sys_rst_i),
    .bus       (bus)
  );

  // ---------------- clock / reset ----------------
  initial ser_clk = 1'b0;
  always #5 ser_clk = ~ser_clk;

  always @(posedge ser_clk) cyc <= cyc + 1;

  // Transmitter model: busy for UART_FRAME_CYCLES cycles after each load.
  always @(posedge ser_clk) begin
    if (bus.uart_wr_o) busy_cnt <= UART_FRAME_CYCLES;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.uart_busy_i = hold_busy | (busy_cnt != 0);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every load strobe must match the head of the expected queue.
  always @(negedge ser_clk) begin
    if (sys_rst_i && bus.uart_wr_o) begin
      n_strobes++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_strobe: got byte %0h expected no strobe (t=%0t)",
                 bus.uart_dat_o, $time);
      end else begin
        check("strobe_data", bus.uart_dat_o, exp_q.pop_front());
      end
      if (check_spacing && have_last) check("strobe_spacing", cyc - last_cyc, 11);
      have_last = 1;
      last_cyc  = cyc;
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge ser_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input bit accepted);
    bus.wr_i  = 1'b1;
    bus.dat_i = b;
    if (accepted) exp_q.push_back(b);
    step();
    bus.wr_i = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.clr_ovf_i = 1'b1;
    step();
    bus.clr_ovf_i = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (exp_q.size() == 0 && bus.idle_o) break;
      step();
    end
    check("drain_done", {31'd0, (exp_q.size() == 0 && bus.idle_o)}, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    sys_rst_i     = 1'b0;
    hold_busy     = 1'b0;
    bus.wr_i      = 1'b0;
    bus.dat_i     = '0;
    bus.clr_ovf_i = 1'b0;
    repeat (3) step();

    check("rst_empty",    bus.empty_o, 1);
    check("rst_full",     bus.full_o, 0);
    check("rst_count",    bus.count_o, 0);
    check("rst_uart_wr",  bus.uart_wr_o, 0);
    check("rst_overflow", bus.overflow_o, 0);
    check("rst_idle",     bus.idle_o, 1);
    sys_rst_i = 1'b1;
    step();

    // Single byte: strobe one cycle after the push, no fall-through.
    bus.wr_i = 1'b1; bus.dat_i = 8'h55;
    #1;
    check("no_fallthrough", bus.uart_wr_o, 0);
    exp_q.push_back(8'h55);
    step();
    bus.wr_i = 1'b0;
    check("single_count1", bus.count_o, 1);
    check("single_strobe", bus.uart_wr_o, 1);
    step();
    check("single_count0", bus.count_o, 0);
    check("single_busy_idle", bus.idle_o, 0);
    repeat (10) step();
    check("single_idle", bus.idle_o, 1);

    // Burst of 8 against the transmitter model.
    check_spacing = 1; have_last = 0;
    for (int i = 1; i <= 8; i++) push(8'(i), 1);
    check("burst_peak_count", bus.count_o, 7);
    wait_idle(200);
    check("burst_overflow", bus.overflow_o, 0);
    check_spacing = 0;

    // Overflow with the transmitter held busy.
    hold_busy = 1'b1;
    for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i), 1);
    check("ovf_full", bus.full_o, 1);
    check("ovf_count8", bus.count_o, 8);
    check("ovf_not_yet", bus.overflow_o, 0);
    push(8'hAF, 0);
    check("ovf_set", bus.overflow_o, 1);
    check("ovf_count_hold", bus.count_o, 8);
    pulse_clr();
    check("ovf_clr", bus.overflow_o, 0);
    bus.clr_ovf_i = 1'b1;
    push(8'hEE, 0);
    bus.clr_ovf_i = 1'b0;
    check("ovf_set_wins", bus.overflow_o, 1);
    base = n_strobes;
    hold_busy = 1'b0;
    wait_idle(200);
    check("ovf_drained_8", n_strobes - base, 8);
    check("ovf_sticky", bus.overflow_o, 1);
    pulse_clr();
    check("ovf_clr2", bus.overflow_o, 0);

    // Push at full on the same cycle the transmitter frees up.
    hold_busy = 1'b1;
    for (int i = 0; i < 8; i++) push(8'hB0 + 8'(i), 1);
    check("fullpop_count8", bus.count_o, 8);
    hold_busy = 1'b0;
    push(8'hB8, 1);
    check("fullpop_count_hold", bus.count_o, 8);
    check("fullpop_no_ovf", bus.overflow_o, 0);
    wait_idle(200);

    // Pointer wrap: 20 bytes, pushing only while not full.
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < 100 && bus.full_o; k++) step();
      push(8'h10 + 8'(i), 1);
    end
    wait_idle(400);

    // Reset mid-stream after the second strobe.
    base = n_strobes;
    for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i), 1);
    for (int k = 0; k < 100 && n_strobes < base + 2; k++) step();
    check("midrst_two_strobes", n_strobes - base, 2);
    check("midrst_count3", bus.count_o, 3);
    sys_rst_i = 1'b0;
    #1;
    check("midrst_empty", bus.empty_o, 1);
    check("midrst_count0", bus.count_o, 0);
    check("midrst_uart_wr", bus.uart_wr_o, 0);
    exp_q.delete();
    repeat (2) step();
    sys_rst_i = 1'b1;
    base = n_strobes;
    repeat (30) step();
    check("postrst_no_strobe", n_strobes - base, 0);
    check("postrst_empty", bus.empty_o, 1);
    push(8'hD5, 1);
    wait_idle(50);
    check("postrst_one_strobe", n_strobes - base, 1);

    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
